// File: rtl/hazard_control_unit.sv
// hazard_control_unit: detects load-use, taken-branch, jump and memory-hold
// hazards and drives the stall/hold/flush enables of a classic 5-stage pipe,
// plus saturating debug counters of stall cycles and flush events.
module hazard_control_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rt,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic                  i_id_is_jump,
    input  logic                  i_mem_branch_taken,
    input  logic                  i_ext_hold,
    input  logic                  i_cnt_clear,
    output logic                  o_stall_pipeline,
    output logic                  o_pc_write_enable,
    output logic                  o_if_id_write_enable,
    output logic                  o_pipe_hold,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_flush,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count
);

    typedef enum logic {RUN, LOAD_STALL} state_t;

    // Remaining bubbles after the first one, loaded when a multi-cycle stall starts
    localparam logic [2:0]       STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0]       STALL_ONE    = 3'd1;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_stall_cnt;
    logic [2:0]       w_next_stall_cnt;
    logic             w_load_use;
    logic             w_flush_event;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    assign w_load_use = i_ex_is_load &&
                        ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

    // Mealy control: priority hold > taken branch > load-use/stall > jump; reset forces idle outputs
    always_comb begin
        o_stall_pipeline     = 1'b0;
        o_pc_write_enable    = 1'b1;
        o_if_id_write_enable = 1'b1;
        o_pipe_hold          = 1'b0;
        o_if_id_flush        = 1'b0;
        o_id_ex_flush        = 1'b0;
        o_ex_mem_flush       = 1'b0;
        w_flush_event        = 1'b0;
        w_next_state         = r_state;
        w_next_stall_cnt     = r_stall_cnt;
        if (!rst) begin
            if (i_ext_hold) begin
                o_pipe_hold          = 1'b1;
                o_pc_write_enable    = 1'b0;
                o_if_id_write_enable = 1'b0;
            end else if (i_mem_branch_taken) begin
                o_if_id_flush    = 1'b1;
                o_id_ex_flush    = 1'b1;
                o_ex_mem_flush   = 1'b1;
                w_flush_event    = 1'b1;
                w_next_state     = RUN;
                w_next_stall_cnt = 3'd0;
            end else if (r_state == LOAD_STALL) begin
                o_stall_pipeline     = 1'b1;
                o_pc_write_enable    = 1'b0;
                o_if_id_write_enable = 1'b0;
                if (r_stall_cnt == STALL_ONE) begin
                    w_next_state     = RUN;
                    w_next_stall_cnt = 3'd0;
                end else begin
                    w_next_stall_cnt = r_stall_cnt - STALL_ONE;
                end
            end else if (w_load_use) begin
                o_stall_pipeline     = 1'b1;
                o_pc_write_enable    = 1'b0;
                o_if_id_write_enable = 1'b0;
                if (LOAD_STALL_CYCLES > 1) begin
                    w_next_state     = LOAD_STALL;
                    w_next_stall_cnt = STALL_RELOAD;
                end
            end else if (i_id_is_jump) begin
                o_if_id_flush = 1'b1;
                w_flush_event = 1'b1;
            end
        end
    end

    // Stall FSM state and bubble counter; hold cycles leave both untouched via the next-state defaults
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= 3'd0;
        end else begin
            r_state     <= w_next_state;
            r_stall_cnt <= w_next_stall_cnt;
        end
    end

    // Saturating debug counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (i_cnt_clear) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (o_stall_pipeline && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end
            if (w_flush_event && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench for hazard_control_unit.
// Instance A uses default parameters; instance B uses a 3-bubble load stall
// and 4-bit counters so saturation is reachable quickly.
module tb_hazard_control_unit;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       isLoad;
        logic [4:0] exRt;
        logic       jump;
        logic       br;
        logic       hold;
        logic       clr;
    } stim_t;

    typedef struct {
        logic        sel;
        logic        rstV;
        stim_t       in;
        logic [6:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    // Control bundle order: {stall, pcWe, ifIdWe, hold, ifIdFlush, idExFlush, exMemFlush}
    localparam logic [6:0] C_RUN   = 7'b0110000;
    localparam logic [6:0] C_STALL = 7'b1000000;
    localparam logic [6:0] C_HOLD  = 7'b0001000;
    localparam logic [6:0] C_BR    = 7'b0110111;
    localparam logic [6:0] C_JMP   = 7'b0110100;

    logic        clk;
    logic        rst;
    stim_t       aIn;
    stim_t       bIn;
    logic [6:0]  aCtl;
    logic [6:0]  bCtl;
    logic [15:0] aSc;
    logic [15:0] aFc;
    logic [3:0]  bSc;
    logic [3:0]  bFc;

    vec_t        stimQ[$];
    vec_t        expQ[$];
    vec_t        cur;
    vec_t        exp;
    logic [6:0]  obsCtl;
    logic [15:0] obsSc;
    logic [15:0] obsFc;
    int          checks;
    int          failures;
    int          step;

    hazard_control_unit dutA (
        .clk                  (clk),
        .rst                  (rst),
        .i_id_rs              (aIn.rs),
        .i_id_rt              (aIn.rt),
        .i_id_uses_rt         (aIn.usesRt),
        .i_ex_is_load         (aIn.isLoad),
        .i_ex_rt              (aIn.exRt),
        .i_id_is_jump         (aIn.jump),
        .i_mem_branch_taken   (aIn.br),
        .i_ext_hold           (aIn.hold),
        .i_cnt_clear          (aIn.clr),
        .o_stall_pipeline     (aCtl[6]),
        .o_pc_write_enable    (aCtl[5]),
        .o_if_id_write_enable (aCtl[4]),
        .o_pipe_hold          (aCtl[3]),
        .o_if_id_flush        (aCtl[2]),
        .o_id_ex_flush        (aCtl[1]),
        .o_ex_mem_flush       (aCtl[0]),
        .o_stall_count        (aSc),
        .o_flush_count        (aFc)
    );

    hazard_control_unit #(
        .REG_ADDR_W        (5),
        .LOAD_STALL_CYCLES (3),
        .CNT_W             (4)
    ) dutB (
        .clk                  (clk),
        .rst                  (rst),
        .i_id_rs              (bIn.rs),
        .i_id_rt              (bIn.rt),
        .i_id_uses_rt         (bIn.usesRt),
        .i_ex_is_load         (bIn.isLoad),
        .i_ex_rt              (bIn.exRt),
        .i_id_is_jump         (bIn.jump),
        .i_mem_branch_taken   (bIn.br),
        .i_ext_hold           (bIn.hold),
        .i_cnt_clear          (bIn.clr),
        .o_stall_pipeline     (bCtl[6]),
        .o_pc_write_enable    (bCtl[5]),
        .o_if_id_write_enable (bCtl[4]),
        .o_pipe_hold          (bCtl[3]),
        .o_if_id_flush        (bCtl[2]),
        .o_id_ex_flush        (bCtl[1]),
        .o_ex_mem_flush       (bCtl[0]),
        .o_stall_count        (bSc),
        .o_flush_count        (bFc)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue one cycle of stimulus together with the outputs it must produce
    task automatic pushVec(input logic sel, input logic rstV, input logic isLoad,
                           input logic [4:0] exRt, input logic [4:0] rs, input logic [4:0] rt,
                           input logic usesRt, input logic jump, input logic br,
                           input logic hold, input logic clr, input logic [6:0] ctl,
                           input logic [15:0] sc, input logic [15:0] fc);
        vec_t v;
        v.sel       = sel;
        v.rstV      = rstV;
        v.in.rs     = rs;
        v.in.rt     = rt;
        v.in.usesRt = usesRt;
        v.in.isLoad = isLoad;
        v.in.exRt   = exRt;
        v.in.jump   = jump;
        v.in.br     = br;
        v.in.hold   = hold;
        v.in.clr    = clr;
        v.ctl       = ctl;
        v.sc        = sc;
        v.fc        = fc;
        stimQ.push_back(v);
    endtask

    // Drive one vector onto the selected instance; the other instance idles
    task automatic applyStimulus(input vec_t v);
        rst = v.rstV;
        if (v.sel) begin
            bIn = v.in;
            aIn = '0;
        end else begin
            aIn = v.in;
            bIn = '0;
        end
    endtask

    // Reset values on both instances, including reset overriding a live load-use
    task automatic test_reset();
        string tname = "reset";
        pushVec(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN, 16'd0, 16'd0);
        pushVec(0, 1, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0, 0, C_RUN, 16'd0, 16'd0);
        pushVec(1, 1, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0, 0, C_RUN, 16'd0, 16'd0);
        pushVec(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN, 16'd0, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN, 16'd0, 16'd0);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // Single-bubble load-use on rs, on register 0, and on rt gated by uses_rt (instance A)
    task automatic test_load_use_single();
        string tname = "load_use_single";
        pushVec(0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd0, 16'd0);
        pushVec(0, 0, 0, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd1, 16'd0);
        pushVec(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd1, 16'd0);
        pushVec(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd1, 16'd0);
        pushVec(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd2, 16'd0);
        pushVec(0, 0, 1, 5'd9, 5'd4, 5'd9, 0, 0, 0, 0, 0, C_RUN,   16'd2, 16'd0);
        pushVec(0, 0, 1, 5'd9, 5'd4, 5'd9, 1, 0, 0, 0, 0, C_STALL, 16'd2, 16'd0);
        pushVec(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd3, 16'd0);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // Jump behind a load-use stalls first then flushes once; plain jump; jump under branch (instance A)
    task automatic test_jump_load_use();
        string tname = "jump_load_use";
        pushVec(0, 0, 1, 5'd15, 5'd15, 5'd0, 0, 1, 0, 0, 0, C_STALL, 16'd3, 16'd0);
        pushVec(0, 0, 0, 5'd0,  5'd15, 5'd0, 0, 1, 0, 0, 0, C_JMP,   16'd4, 16'd0);
        pushVec(0, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd4, 16'd1);
        pushVec(0, 0, 0, 5'd0,  5'd2,  5'd0, 0, 1, 0, 0, 0, C_JMP,   16'd4, 16'd1);
        pushVec(0, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd4, 16'd2);
        pushVec(0, 0, 0, 5'd0,  5'd2,  5'd0, 0, 1, 1, 0, 0, C_BR,    16'd4, 16'd2);
        pushVec(0, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd4, 16'd3);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // Three-bubble stall on rt, then the same pair with uses_rt low (instance B)
    task automatic test_load_stall_multi();
        string tname = "load_stall_multi";
        pushVec(1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, 0, C_STALL, 16'd0, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd1, 5'd7, 1, 0, 0, 0, 0, C_STALL, 16'd1, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd1, 5'd7, 1, 0, 0, 0, 0, C_STALL, 16'd2, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd1, 5'd7, 1, 0, 0, 0, 0, C_RUN,   16'd3, 16'd0);
        pushVec(1, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 0, C_RUN,   16'd3, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd3, 16'd0);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // Taken branch in the second bubble aborts the stall (instance B)
    task automatic test_branch_abort();
        string tname = "branch_abort";
        pushVec(1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd3, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd7, 5'd0, 0, 0, 1, 0, 0, C_BR,    16'd4, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd4, 16'd1);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd4, 16'd1);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // Hold masks a pending branch for 4 cycles, then a hold freezes a stall mid-way (instance B)
    task automatic test_hold_branch();
        string tname = "hold_branch";
        for (int i = 0; i < 4; i++) begin
            pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, C_HOLD, 16'd4, 16'd1);
        end
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, C_BR,    16'd4, 16'd1);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd4, 16'd2);
        pushVec(1, 0, 1, 5'd6, 5'd6, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd4, 16'd2);
        pushVec(1, 0, 0, 5'd0, 5'd6, 5'd0, 0, 0, 0, 1, 0, C_HOLD,  16'd5, 16'd2);
        pushVec(1, 0, 0, 5'd0, 5'd6, 5'd0, 0, 0, 0, 1, 0, C_HOLD,  16'd5, 16'd2);
        pushVec(1, 0, 0, 5'd0, 5'd6, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd5, 16'd2);
        pushVec(1, 0, 0, 5'd0, 5'd6, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd6, 16'd2);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd7, 16'd2);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // 21 back-to-back stall cycles saturate the 4-bit counter, then clear during a stall (instance B)
    task automatic test_saturation();
        string tname = "saturation";
        int    want;
        for (int i = 0; i < 21; i++) begin
            want = (7 + i > 15) ? 15 : 7 + i;
            pushVec(1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'(want), 16'd2);
        end
        pushVec(1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 1, C_STALL, 16'd15, 16'd2);
        pushVec(1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd0,  16'd0);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // Reset asserted while B sits in LOAD_STALL with two bubbles left must land in RUN
    task automatic test_reset_mid_stall();
        string tname = "reset_mid_stall";
        pushVec(1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd1, 16'd0);
        pushVec(1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, C_STALL, 16'd2, 16'd0);
        pushVec(1, 1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        pushVec(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        step = 0;
        while (stimQ.size() > 0) begin
            cur = stimQ.pop_front();
            @(negedge clk);
            applyStimulus(cur);
            expQ.push_back(cur);
            #1;
            exp    = expQ.pop_front();
            obsCtl = exp.sel ? bCtl : aCtl;
            obsSc  = exp.sel ? {12'd0, bSc} : aSc;
            obsFc  = exp.sel ? {12'd0, bFc} : aFc;
            checks += 3;
            if (obsCtl !== exp.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl step=%0d got=%b want=%b", tname, step, obsCtl, exp.ctl);
            end
            if (obsSc !== exp.sc) begin
                failures++;
                $display("[TB] FAIL %s stall_count step=%0d got=%0d want=%0d", tname, step, obsSc, exp.sc);
            end
            if (obsFc !== exp.fc) begin
                failures++;
                $display("[TB] FAIL %s flush_count step=%0d got=%0d want=%0d", tname, step, obsFc, exp.fc);
            end
            step++;
        end
    endtask

    // Test sequence: instance A scenarios first, then instance B scenarios that chain counter values
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        aIn      = '0;
        bIn      = '0;
        $display("[TB] start");
        test_reset();
        test_load_use_single();
        test_jump_load_use();
        test_load_stall_multi();
        test_branch_abort();
        test_hold_branch();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer of the `stall_pipeline` signal consumed by the instruction decoder.
- Detects load-use hazards (load in EX, dependent instruction in ID), taken branches resolved in MEM, unconditional jumps resolved in ID, and external memory holds.
- Drives stall, hold and flush enables for the PC and the pipeline registers, and keeps saturating stall/flush event counters for debug.

Parameters:
REG_ADDR_W, 5, width of register address fields
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 16, width of event counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs  in  REG_ADDR_W  rs field of instruction in ID
id_rt  in  REG_ADDR_W  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq/bne, store)
ex_is_load  in  1  instruction in EX is a load
ex_rt  in  REG_ADDR_W  destination register of instruction in EX
id_is_jump  in  1  jump (j/jal/jr) decoded in ID
mem_branch_taken  in  1  branch in MEM resolved taken
ext_hold  in  1  memory not ready; freeze whole pipeline
cnt_clear  in  1  synchronous clear of counters
stall_pipeline  out  1  to decoder: emit all-zero controls (bubble into ID/EX)
pc_write_enable  out  1  PC update enable
if_id_write_enable  out  1  IF/ID register enable
pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
if_id_flush  out  1  clear IF/ID on next edge
id_ex_flush  out  1  clear ID/EX on next edge
ex_mem_flush  out  1  clear EX/MEM on next edge
stall_count  out  CNT_W  cycles with stall_pipeline=1, saturating
flush_count  out  CNT_W  flush events (branch or jump), saturating

Behaviour:
- Clock, reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=RUN, stall counter=0, stall_count=0, flush_count=0. Outputs at reset: pc_write_enable=1, if_id_write_enable=1, all others 0.
- Outputs are Mealy: a function of state plus current inputs. No input-to-effect latency beyond the next clock edge.
- Hazard condition: load_use = ex_is_load && ((ex_rt==id_rs) || (id_uses_rt && ex_rt==id_rt)). Register 0 is not special.
- Priority, highest first: ext_hold > mem_branch_taken > load-use/stall state > id_is_jump.
- ext_hold=1:
  - pipe_hold=1, pc_write_enable=0, if_id_write_enable=0; all flushes 0; stall_pipeline=0.
  - State and stall counter do not change; counters do not increment.
  - A branch held in MEM is acted on in the first cycle after hold drops.
- mem_branch_taken=1 (no hold):
  - if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write_enable=1.
  - stall_pipeline=0; jump flush suppressed.
  - Next state RUN, stall counter cleared. This aborts an in-progress LOAD_STALL, because the load and its consumer are both younger than the branch.
  - flush_count +1.
- FSM states: RUN, LOAD_STALL.
- RUN, load_use=1, no branch:
  - stall_pipeline=1, pc_write_enable=0, if_id_write_enable=0.
  - If LOAD_STALL_CYCLES>1: go to LOAD_STALL, counter loaded with LOAD_STALL_CYCLES-1.
  - Otherwise stay in RUN; the EX load advances, so load_use clears next cycle.
- LOAD_STALL:
  - stall_pipeline=1, PC and IF/ID frozen; load_use is ignored (EX holds a bubble).
  - Counter decrements each non-hold cycle; at counter==1 return to RUN.
- RUN, no hazard, id_is_jump=1: if_id_flush=1 (kills the fall-through fetch), pc_write_enable=1, flush_count +1.
- Jump with concurrent load-use (e.g. jr on a loaded rs): the stall is taken first. The jump stays in ID and is flushed on the first non-stall cycle; it is counted once.
- Counters:
  - stall_count +1 each cycle stall_pipeline=1.
  - Both counters saturate at all-ones.
  - cnt_clear zeroes both at the edge and takes precedence over increment in the same cycle.
- Reset mid-stall returns to RUN immediately (asynchronously), with outputs at their reset values.

Test Plan:
- Reset, then ex_is_load=1, ex_rt=3, id_rs=3 for one cycle, next cycle ex_is_load=0 -> stall_pipeline=1, pc_write_enable=0 for exactly 1 cycle; stall_count=1; no flush.
- LOAD_STALL_CYCLES=3, load ex_rt=7, id_rt=7, id_uses_rt=1 -> stall_pipeline high 3 consecutive cycles, stall_count=3. Repeat with id_uses_rt=0 -> no stall.
- mem_branch_taken=1 during 2nd cycle of a 3-cycle load stall -> all three flushes=1 that cycle, stall_pipeline=0, next cycle RUN with no stall, flush_count=1.
- ext_hold=1 for 4 cycles while mem_branch_taken=1 -> pipe_hold=1, no flushes, counters unchanged; first cycle after hold drops -> flushes asserted once, flush_count=1.
- id_is_jump=1 with load-use on rs=15 -> 1 stall cycle with if_id_flush=0, then if_id_flush=1 for 1 cycle; flush_count=1, stall_count=1.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) -> stall_count holds 15. cnt_clear with simultaneous stall -> stall_count=0.
